// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read-only slave serving a locally written 32-bit register file.
// One outstanding read; RVALID follows the AR handshake by RD_LATENCY+1 cycles.
module axi_lite_read_slave #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic        lw_en,
    input  logic [7:0]  lw_idx,
    input  logic [31:0] lw_data,
    output logic [15:0] txn_count
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_KW = 10;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TXN_W   = 16;
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_arready;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [ADDR_KW-1:0]    r_addr;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic [1:0]            r_rresp;
    logic [TXN_W-1:0]      r_txn_count;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_rsp_load;
    logic [ADDR_KW-1:0]    w_rd_addr;
    logic [7:0]            w_rd_idx;
    logic [IDX_W-1:0]      w_rd_slot;
    logic                  w_rd_ok;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_lw_hit;
    logic [IDX_W-1:0]      w_lw_slot;
    logic                  w_unused;

    // Upper address bits do not take part in decode.
    assign w_unused = ^ARADDR[31:ADDR_KW];

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ARVALID && r_arready) begin
                    w_ar_hs      = 1'b1;
                    w_next_state = (RD_LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt <= CNT_W'(1)) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (r_rvalid && RREADY) begin
                    w_r_hs       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_rsp_load = (w_next_state == RESP) && (r_state != RESP);

    // State register, ARREADY, address capture and wait counter.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_state    <= IDLE;
            r_arready  <= 1'b0;
            r_wait_cnt <= '0;
            r_addr     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_arready <= (w_next_state == IDLE);
            if (w_ar_hs) begin
                r_addr     <= ARADDR[ADDR_KW-1:0];
                r_wait_cnt <= CNT_W'(RD_LATENCY);
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
        end
    end

    // With zero latency the response is built from the live address in the accept cycle.
    assign w_rd_addr = (r_state == IDLE) ? ARADDR[ADDR_KW-1:0] : r_addr;
    assign w_rd_idx  = w_rd_addr[ADDR_KW-1:2];
    assign w_rd_slot = w_rd_idx[IDX_W-1:0];
    assign w_rd_ok   = (w_rd_addr[1:0] == 2'b00) && (9'(w_rd_idx) < 9'(NUM_REGS));
    assign w_rd_word = r_regs[w_rd_slot];

    assign w_lw_hit  = lw_en && (9'(lw_idx) < 9'(NUM_REGS));
    assign w_lw_slot = lw_idx[IDX_W-1:0];

    // Register file; a same-edge read sees the pre-write contents.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg
        always_ff @(posedge ACLK or posedge ARESETn) begin
            if (ARESETn) begin
                r_regs[g] <= '0;
            end else if (w_lw_hit && (w_lw_slot == IDX_W'(g))) begin
                r_regs[g] <= lw_data;
            end
        end
    end

    // Read response channel and handshake counter.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_txn_count <= '0;
        end else begin
            if (w_rsp_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_ok ? w_rd_word : '0;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
                r_rresp  <= RESP_OKAY;
            end
            if (w_r_hs) begin
                r_txn_count <= r_txn_count + TXN_W'(1);
            end
        end
    end

    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RRESP     = r_rresp;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed scoreboard bench for axi_lite_read_slave: index 0 uses RD_LATENCY=2,
// index 1 uses RD_LATENCY=0; both share clock and reset.
module tb_axi_lite_read_slave;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic        lw_en   [2];
    logic [7:0]  lw_idx  [2];
    logic [31:0] lw_data [2];
    logic [15:0] txn     [2];

    logic [31:0] mdl [2][8];
    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    axi_lite_read_slave #(.NUM_REGS(8), .RD_LATENCY(2)) dut (
        .ACLK(clk), .ARESETn(rst),
        .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
        .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
        .lw_en(lw_en[0]), .lw_idx(lw_idx[0]), .lw_data(lw_data[0]),
        .txn_count(txn[0])
    );

    axi_lite_read_slave #(.NUM_REGS(8), .RD_LATENCY(0)) dut0 (
        .ACLK(clk), .ARESETn(rst),
        .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
        .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
        .lw_en(lw_en[1]), .lw_idx(lw_idx[1]), .lw_data(lw_data[1]),
        .txn_count(txn[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t expect_of(input logic d, input logic [31:0] a);
        exp_t e;
        if (a[1:0] == 2'b00 && a[9:5] == 5'd0) begin
            e.d = mdl[d][a[4:2]];
            e.r = 2'b00;
        end else begin
            e.d = 32'h0;
            e.r = 2'b10;
        end
        return e;
    endfunction

    task automatic clear_model();
        foreach (mdl[i, j]) mdl[i][j] = 32'h0;
    endtask

    // Local register write; starts and ends on a falling edge.
    task automatic lw(input logic d, input logic [7:0] idx, input logic [31:0] data);
        lw_en[d]   = 1'b1;
        lw_idx[d]  = idx;
        lw_data[d] = data;
        @(negedge clk);
        lw_en[d] = 1'b0;
        if (idx < 8'd8) mdl[d][idx[2:0]] = data;
    endtask

    // Full read with optional RREADY stall; starts and ends on a falling edge.
    task automatic do_read(input logic d, input logic [31:0] addr, input int stall);
        exp_t        e;
        int          n;
        int          exp_lat;
        logic [15:0] t0;
        exp_lat    = d ? 0 : 2;
        rready[d]  = 1'b0;
        araddr[d]  = addr;
        arvalid[d] = 1'b1;
        n = 0;
        while (arready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", 32'(arready[d]), 32'd1);
        sb.push_back(expect_of(d, addr));
        @(negedge clk);
        arvalid[d] = 1'b0;
        araddr[d]  = 32'h0;
        chk("ar_busy", 32'(arready[d]), 32'd0);
        n = 1;
        while (rvalid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_latency", 32'(n), 32'(exp_lat + 1));
        e = sb.pop_front();
        for (int k = 0; k < stall; k++) begin
            arvalid[d] = (k % 2) == 1;
            araddr[d]  = 32'h4;
            @(negedge clk);
            chk("hold_rvalid", 32'(rvalid[d]), 32'd1);
            chk("hold_rdata", rdata[d], e.d);
            chk("hold_rresp", 32'(rresp[d]), 32'(e.r));
            chk("hold_arready", 32'(arready[d]), 32'd0);
        end
        arvalid[d] = 1'b0;
        chk("rdata", rdata[d], e.d);
        chk("rresp", 32'(rresp[d]), 32'(e.r));
        t0 = txn[d];
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
        chk("done_rvalid", 32'(rvalid[d]), 32'd0);
        chk("done_arready", 32'(arready[d]), 32'd1);
        chk("idle_rdata", rdata[d], 32'h0);
        chk("idle_rresp", 32'(rresp[d]), 32'd0);
        chk("txn_inc", 32'(txn[d]), 32'(16'(t0 + 16'd1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        for (int i = 0; i < 2; i++) begin
            araddr[i] = 32'h0; arvalid[i] = 1'b0; rready[i] = 1'b0;
            lw_en[i] = 1'b0; lw_idx[i] = 8'h0; lw_data[i] = 32'h0;
        end
        clear_model();
        rst = 1'b1;

        // Reset values while reset is held
        @(negedge clk);
        chk("rst_arready", 32'(arready[0]), 32'd0);
        chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_rresp", 32'(rresp[0]), 32'd0);
        chk("rst_txn", 32'(txn[0]), 32'd0);
        chk("rst_arready0", 32'(arready[1]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arready", 32'(arready[0]), 32'd1);
        chk("rel_arready0", 32'(arready[1]), 32'd1);

        // Basic read of reg2
        lw(1'b0, 8'd2, 32'hDEADBEEF);
        do_read(1'b0, 32'h08, 0);
        chk("txn_first", 32'(txn[0]), 32'd1);

        // Stalled read with ignored ARVALID pulses
        lw(1'b0, 8'd3, 32'h12345678);
        do_read(1'b0, 32'h0C, 5);

        // Error decode and boundary registers
        do_read(1'b0, 32'h20, 0);
        do_read(1'b0, 32'h05, 0);
        lw(1'b0, 8'd7, 32'h7777_0007);
        lw(1'b0, 8'd8, 32'hBAD0_0008);
        do_read(1'b0, 32'h1C, 0);
        do_read(1'b0, 32'h00, 1);
        do_read(1'b0, 32'h402, 0);

        // Zero-latency instance, back-to-back reads
        lw(1'b1, 8'd1, 32'hA5A5_5A5A);
        lw(1'b1, 8'd6, 32'h0000_F00D);
        do_read(1'b1, 32'h04, 0);
        do_read(1'b1, 32'h18, 0);
        do_read(1'b1, 32'h24, 0);
        do_read(1'b1, 32'h04, 2);

        // Same-edge local write on zero-latency accept returns old data
        old = mdl[1][1];
        araddr[1] = 32'h04; arvalid[1] = 1'b1;
        lw_en[1] = 1'b1; lw_idx[1] = 8'd1; lw_data[1] = 32'hC0FF_EE00;
        chk("coll0_arready", 32'(arready[1]), 32'd1);
        @(negedge clk);
        arvalid[1] = 1'b0; lw_en[1] = 1'b0;
        mdl[1][1] = 32'hC0FF_EE00;
        chk("coll0_rvalid", 32'(rvalid[1]), 32'd1);
        chk("coll0_old", rdata[1], old);
        rready[1] = 1'b1;
        @(negedge clk);
        rready[1] = 1'b0;
        do_read(1'b1, 32'h04, 0);

        // Same-edge local write on RESP entry after the wait phase
        old = mdl[0][2];
        araddr[0] = 32'h08; arvalid[0] = 1'b1;
        chk("coll2_arready", 32'(arready[0]), 32'd1);
        @(negedge clk);
        arvalid[0] = 1'b0;
        @(negedge clk);
        lw_en[0] = 1'b1; lw_idx[0] = 8'd2; lw_data[0] = 32'h1111_2222;
        @(negedge clk);
        lw_en[0] = 1'b0;
        mdl[0][2] = 32'h1111_2222;
        chk("coll2_rvalid", 32'(rvalid[0]), 32'd1);
        chk("coll2_old", rdata[0], old);
        rready[0] = 1'b1;
        @(negedge clk);
        rready[0] = 1'b0;
        do_read(1'b0, 32'h08, 0);

        // Handshake counter wrap
        force dut0.r_txn_count = 16'hFFFF;
        @(negedge clk);
        release dut0.r_txn_count;
        @(negedge clk);
        chk("txn_preset", 32'(txn[1]), 32'h0000FFFF);
        do_read(1'b1, 32'h04, 0);
        chk("txn_wrap", 32'(txn[1]), 32'd0);

        // Reset during the wait phase aborts the read
        araddr[0] = 32'h08; arvalid[0] = 1'b1;
        chk("abort_arready", 32'(arready[0]), 32'd1);
        @(negedge clk);
        arvalid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        clear_model();
        chk("abort_rst_arready", 32'(arready[0]), 32'd0);
        chk("abort_rst_rvalid", 32'(rvalid[0]), 32'd0);
        chk("abort_rst_txn", 32'(txn[0]), 32'd0);
        chk("abort_rst_txn0", 32'(txn[1]), 32'd0);
        @(negedge clk);
        chk("abort_hold_rvalid", 32'(rvalid[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rel_arready", 32'(arready[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 32'(rvalid[0]), 32'd0);
        end
        do_read(1'b0, 32'h08, 0);
        chk("post_rst_txn", 32'(txn[0]), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_slave.md
AXI_LITE_READ_SLAVE -- requirements
Module: axi_lite_read_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of 32-bit readable registers (1..256).
REQ-002 SHALL have parameter RD_LATENCY, default 2, wait cycles between address acceptance and RVALID (0..15).
REQ-003 SHALL have port ACLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ARADDR  input  32  read byte address.
REQ-006 SHALL have port ARVALID  input  1  master address valid.
REQ-007 SHALL have port ARREADY  output  1  slave ready to accept address.
REQ-008 SHALL have port RDATA  output  32  read data.
REQ-009 SHALL have port RRESP  output  2  response; 2'b00 OKAY, 2'b10 SLVERR.
REQ-010 SHALL have port RVALID  output  1  read data valid.
REQ-011 SHALL have port RREADY  input  1  master ready for read data.
REQ-012 SHALL have port lw_en  input  1  local register-file write strobe.
REQ-013 SHALL have port lw_idx  input  8  local write register index.
REQ-014 SHALL have port lw_data  input  32  local write data.
REQ-015 SHALL have port txn_count  output  16  completed read handshakes, wrapping.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding read maximum.
REQ-017 SHALL drive ARREADY=1 only in IDLE (registered, from state).
REQ-018 SHALL, in IDLE on ARVALID&&ARREADY, latch ARADDR and load wait counter with RD_LATENCY; go to WAIT if RD_LATENCY>0, else RESP next cycle.
REQ-019 SHALL, in WAIT, decrement counter each cycle; on counter==1 go to RESP next cycle (exactly RD_LATENCY cycles in WAIT).
REQ-020 SHALL load RDATA/RRESP and assert RVALID on entry to RESP; minimum AR-handshake-to-RVALID latency = RD_LATENCY+1 cycles.
REQ-021 SHALL hold RVALID, RDATA, RRESP stable in RESP until RVALID&&RREADY sampled high.
REQ-022 SHALL, on R handshake, go to IDLE: RVALID=0 and ARREADY=1 next cycle; RREADY high on RVALID's first cycle completes in one cycle.
REQ-023 SHALL ignore ARVALID while in WAIT or RESP (ARREADY low, no capture).
REQ-024 SHALL decode index = latched ARADDR[9:2]; OKAY with register contents iff ARADDR[1:0]==2'b00 and index<NUM_REGS.
REQ-025 SHALL return RRESP=2'b10 and RDATA=32'h0 for misaligned or out-of-range addresses; no other side effect.
REQ-026 SHALL drive RDATA=0 and RRESP=2'b00 whenever RVALID=0.
REQ-027 SHALL write lw_data to register lw_idx on rising edge with lw_en=1; lw_idx>=NUM_REGS ignored.
REQ-028 SHALL, when local write and RESP-entry data load hit the same register in the same cycle, return the pre-write (old) value.
REQ-029 SHALL accept local writes in every state, independent of the AXI FSM.
REQ-030 SHALL increment txn_count on every R handshake (OKAY or SLVERR), wrapping 16'hFFFF->16'h0000.

Reset
REQ-031 SHALL, while ARESETn=1, immediately force state IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, txn_count=0, wait counter=0, all registers=0.
REQ-032 SHALL, on first rising ACLK after ARESETn falls, drive ARREADY=1.
REQ-033 SHALL abort any in-flight read on reset; no RVALID for it after release.

Verification
REQ-034 Bench SHALL cover: lw write reg2=32'hDEADBEEF; AR 0x08, RREADY=1 -> RVALID 3 cycles after AR handshake, RDATA=DEADBEEF, RRESP=00, txn_count=1.
REQ-035 Bench SHALL cover: AR 0x0C with RREADY=0 for 5 cycles -> RVALID/RDATA/RRESP stable all 5 cycles; ARVALID pulses ignored; completes when RREADY=1.
REQ-036 Bench SHALL cover: AR 0x20 (index 8) and AR 0x05 -> RRESP=10, RDATA=0 for both.
REQ-037 Bench SHALL cover: RD_LATENCY=0 -> RVALID 1 cycle after AR handshake; back-to-back reads with RREADY=1 -> ARREADY high next cycle after each R handshake.
REQ-038 Bench SHALL cover: ARESETn=1 during WAIT -> RVALID stays 0, ARREADY 0, txn_count=0; after release ARREADY=1 next edge.
REQ-039 Bench SHALL cover: preset txn_count to 16'hFFFF via 65535 reads (or forced) -> next handshake gives 16'h0000.
